// File: rtl/fft_pkg.sv
// Shared FFT datapath constants: power width and complex component packing.
// Used by the FFT wrapper, power stage and output controller.
package fft_pkg;

   localparam int RE_LSB = 0;

   function automatic int pow_w(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int im_lsb(input int data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/fft_power_stage_if.sv
// Stream bundle around the power stage: complex bins in, tagged power out.
// Signal names are from the power stage's point of view.
interface fft_power_stage_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 10
);
   import fft_pkg::*;

   logic [2*DATA_W-1:0]        i_data;
   logic                       i_data_valid;
   logic                       o_data_ready;
   logic [pow_w(DATA_W)-1:0]   o_data;
   logic [IDX_W-1:0]           o_index;
   logic                       o_last;
   logic                       o_data_valid;
   logic                       i_data_ready;

   modport master (
      output i_data, i_data_valid, i_data_ready,
      input  o_data_ready, o_data, o_index, o_last, o_data_valid
   );

   modport slave (
      input  i_data, i_data_valid, i_data_ready,
      output o_data_ready, o_data, o_index, o_last, o_data_valid
   );

endinterface

// File: rtl/cmplx_mag_sq.sv
// Enable-gated squared magnitude pipeline, PIPE_STAGES deep.
// A sideband tag and valid bit travel alongside each sample.
module cmplx_mag_sq
   import fft_pkg::*;
#(
   parameter  int DATA_W      = 16,
   parameter  int PIPE_STAGES = 2,
   parameter  int TAG_W       = 1,
   localparam int POW_W       = pow_w(DATA_W)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_en,
   input  logic                i_valid,
   input  logic [2*DATA_W-1:0] i_data,
   input  logic [TAG_W-1:0]    i_tag,
   output logic                o_valid,
   output logic [POW_W-1:0]    o_pow,
   output logic [TAG_W-1:0]    o_tag
);

   logic signed [DATA_W-1:0] re_s, im_s;
   logic                     v_s;
   logic [TAG_W-1:0]         tag_s;

   generate
      if (PIPE_STAGES == 3) begin : g_in_reg
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               re_s  <= '0;
               im_s  <= '0;
               v_s   <= 1'b0;
               tag_s <= '0;
            end else if (i_en) begin
               re_s  <= i_data[RE_LSB +: DATA_W];
               im_s  <= i_data[im_lsb(DATA_W) +: DATA_W];
               v_s   <= i_valid;
               tag_s <= i_tag;
            end
         end
      end else begin : g_no_reg
         assign re_s  = i_data[RE_LSB +: DATA_W];
         assign im_s  = i_data[im_lsb(DATA_W) +: DATA_W];
         assign v_s   = i_valid;
         assign tag_s = i_tag;
      end
   endgenerate

   // Sign-extend before squaring; each square is non-negative and fits.
   logic signed [POW_W-1:0] re_x, im_x, re_p, im_p;
   assign re_x = POW_W'(re_s);
   assign im_x = POW_W'(im_s);
   assign re_p = re_x * re_x;
   assign im_p = im_x * im_x;

   logic [POW_W-1:0] re_sq, im_sq;
   logic             v_a;
   logic [TAG_W-1:0] tag_a;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         re_sq <= '0;
         im_sq <= '0;
         v_a   <= 1'b0;
         tag_a <= '0;
      end else if (i_en) begin
         re_sq <= re_p;
         im_sq <= im_p;
         v_a   <= v_s;
         tag_a <= tag_s;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_pow   <= '0;
         o_valid <= 1'b0;
         o_tag   <= '0;
      end else if (i_en) begin
         o_pow   <= re_sq + im_sq;
         o_valid <= v_a;
         o_tag   <= tag_a;
      end
   end

endmodule

// File: rtl/fft_power_stage.sv
// FFT bin power stage: |X|^2 per bin with bin tagging and per-frame peak.
// Back-pressure stalls the whole pipeline; peak report is not back-pressured.
module fft_power_stage
   import fft_pkg::*;
#(
   parameter  int DATA_W       = 16,
   parameter  int FFT_LEN_LOG2 = 10,
   parameter  int PIPE_STAGES  = 2,
   localparam int POW_W        = pow_w(DATA_W)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_sync,
   fft_power_stage_if.slave        bus,
   output logic                    o_peak_valid,
   output logic [FFT_LEN_LOG2-1:0] o_peak_index,
   output logic [POW_W-1:0]        o_peak_power
);

   localparam int IDX_W = FFT_LEN_LOG2;

   logic             en, accept, xfer, take;
   logic [IDX_W-1:0] bin_cnt, bin_idx, trk_idx;
   logic [IDX_W:0]   out_tag;
   logic [POW_W-1:0] trk_pow;

   assign en               = !bus.o_data_valid || bus.i_data_ready;
   assign bus.o_data_ready = en;
   assign accept           = bus.i_data_valid && en;
   assign bin_idx          = i_sync ? '0 : bin_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bin_cnt <= '0;
      end else if (accept) begin
         bin_cnt <= bin_idx + IDX_W'(1);
      end else if (i_sync) begin
         bin_cnt <= '0;
      end
   end

   cmplx_mag_sq #(
      .DATA_W      (DATA_W),
      .PIPE_STAGES (PIPE_STAGES),
      .TAG_W       (IDX_W + 1)
   ) u_mag (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (en),
      .i_valid (accept),
      .i_data  (bus.i_data),
      .i_tag   ({&bin_idx, bin_idx}),
      .o_valid (bus.o_data_valid),
      .o_pow   (bus.o_data),
      .o_tag   (out_tag)
   );

   assign bus.o_index = out_tag[IDX_W-1:0];
   assign bus.o_last  = out_tag[IDX_W];

   // Bin 0 always reloads; strict compare keeps the lowest index on ties.
   assign xfer = bus.o_data_valid && bus.i_data_ready;
   assign take = (bus.o_index == '0) || (bus.o_data > trk_pow);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         trk_idx      <= '0;
         trk_pow      <= '0;
         o_peak_valid <= 1'b0;
         o_peak_index <= '0;
         o_peak_power <= '0;
      end else begin
         o_peak_valid <= xfer && bus.o_last;
         if (xfer && take) begin
            trk_idx <= bus.o_index;
            trk_pow <= bus.o_data;
         end
         if (xfer && bus.o_last) begin
            o_peak_index <= take ? bus.o_index : trk_idx;
            o_peak_power <= take ? bus.o_data : trk_pow;
         end
      end
   end

endmodule

// File: tb/tb_fft_power_stage.sv
// Bench for fft_power_stage: directed steps with random bins,
// checked against a queue-based power/index/peak reference.
module tb_fft_power_stage;

   localparam int DW = 16;
   localparam int LG = 3;
   localparam int PS = 2;
   localparam int N  = 8;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          sync  = 1'b0;
   logic          pv;
   logic [LG-1:0] pidx;
   logic [31:0]   ppow;

   fft_power_stage_if #(.DATA_W(DW), .IDX_W(LG)) bus ();

   fft_power_stage #(
      .DATA_W       (DW),
      .FFT_LEN_LOG2 (LG),
      .PIPE_STAGES  (PS)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_sync       (sync),
      .bus          (bus),
      .o_peak_valid (pv),
      .o_peak_index (pidx),
      .o_peak_power (ppow)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   typedef struct {
      longint pw;
      int     idx;
   } smp_t;

   smp_t   q[$];
   longint fr_pw[$];
   int     mcnt;
   bit     peak_due;
   int     exp_pi;
   longint exp_pp;

   // Reference: every accepted bin is queued with its power and bin number;
   // outputs must leave in order, and a completed frame yields its first max.
   always @(negedge clk) begin
      smp_t   e;
      int     k;
      longint re, im;
      if (!rst_n) begin
         q.delete();
         fr_pw.delete();
         mcnt     = 0;
         peak_due = 0;
      end else begin
         chk("peak_valid", 64'(pv), 64'(peak_due));
         if (peak_due) begin
            chk("peak_index", 64'(pidx), 64'(exp_pi));
            chk("peak_power", 64'(ppow), 64'(exp_pp));
         end
         peak_due = 0;
         if (bus.o_data_valid && bus.i_data_ready) begin
            if (q.size() == 0) begin
               chk("spurious_out", 64'(bus.o_data_valid), 64'(0));
            end else begin
               e = q.pop_front();
               chk("out_power", 64'(bus.o_data), 64'(e.pw));
               chk("out_index", 64'(bus.o_index), 64'(e.idx));
               chk("out_last", 64'(bus.o_last), 64'(e.idx == N - 1));
               if (e.idx == 0) fr_pw.delete();
               fr_pw.push_back(e.pw);
               if (e.idx == N - 1) begin
                  exp_pi = 0;
                  exp_pp = fr_pw[0];
                  for (int i = 1; i < fr_pw.size(); i++)
                     if (fr_pw[i] > exp_pp) begin
                        exp_pi = i;
                        exp_pp = fr_pw[i];
                     end
                  peak_due = 1;
               end
            end
         end
         if (bus.i_data_valid && bus.o_data_ready) begin
            re = longint'($signed(bus.i_data[DW-1:0]));
            im = longint'($signed(bus.i_data[2*DW-1:DW]));
            k  = sync ? 0 : mcnt;
            q.push_back('{re * re + im * im, k});
            mcnt = (k + 1) % N;
         end else if (sync) begin
            mcnt = 0;
         end
      end
   end

   task automatic send(input int re, input int im, input bit s);
      @(posedge clk);
      #1;
      bus.i_data       = {16'(im), 16'(re)};
      bus.i_data_valid = 1'b1;
      sync             = s;
      for (int t = 0; ; t++) begin
         @(negedge clk);
         if (bus.o_data_ready) break;
         if (t > 50) begin
            chk("send_timeout", 64'(bus.o_data_ready), 64'(1));
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.i_data_valid = 1'b0;
         bus.i_data       = $urandom;
         sync             = 1'b0;
      end
   endtask

   function automatic int rnd16();
      return int'($signed(16'($urandom)));
   endfunction

   int          t_re[N] = '{1, 3, 0, 0, 0, 1, -3, 0};
   int          t_im[N] = '{0, 0, -2, 3, 0, 1, 0, 1};
   logic [31:0] held;
   logic [2:0]  hidx;
   bit          seen;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_data       = '0;
      bus.i_data_valid = 1'b0;
      bus.i_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(bus.o_data_valid), 64'(0));
      chk("rst_data", 64'(bus.o_data), 64'(0));
      chk("rst_index", 64'(bus.o_index), 64'(0));
      chk("rst_last", 64'(bus.o_last), 64'(0));
      chk("rst_pv", 64'(pv), 64'(0));
      chk("rst_pidx", 64'(pidx), 64'(0));
      chk("rst_ppow", 64'(ppow), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(bus.o_data_ready), 64'(1));

      // 3 - 4j -> 25, bin 0, two cycles after acceptance
      send(3, -4, 1'b0);
      @(posedge clk);
      #1;
      bus.i_data_valid = 1'b0;
      chk("lat_early", 64'(bus.o_data_valid), 64'(0));
      @(posedge clk);
      #1;
      chk("lat_valid", 64'(bus.o_data_valid), 64'(1));
      chk("pow_3_4", 64'(bus.o_data), 64'(25));
      chk("idx_first", 64'(bus.o_index), 64'(0));

      // most negative components: exact 2^31
      send(-32768, -32768, 1'b0);
      @(posedge clk);
      #1;
      bus.i_data_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("pow_min", 64'(bus.o_data), 64'h8000_0000);
      chk("idx_second", 64'(bus.o_index), 64'(1));
      idle(3);

      // fixed frame, powers 1,9,4,9,0,2,9,1
      for (int i = 0; i < N; i++) send(t_re[i], t_im[i], i == 0);
      idle(1);
      seen = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (pv) begin
            seen = 1;
            break;
         end
      end
      chk("frame_pulse", 64'(seen), 64'(1));
      chk("frame_pidx", 64'(pidx), 64'(1));
      chk("frame_ppow", 64'(ppow), 64'(9));
      @(negedge clk);
      chk("pulse_one_cycle", 64'(pv), 64'(0));
      chk("peak_stable", 64'(ppow), 64'(9));

      // back-pressure for 5 cycles with input still offered
      for (int i = 0; i < 3; i++) send(rnd16(), rnd16(), i == 0);
      @(posedge clk);
      #1;
      bus.i_data_ready = 1'b0;
      bus.i_data       = {16'($urandom), 16'($urandom)};
      bus.i_data_valid = 1'b1;
      sync             = 1'b0;
      @(negedge clk);
      held = bus.o_data;
      hidx = bus.o_index;
      repeat (5) begin
         chk("stall_ready", 64'(bus.o_data_ready), 64'(0));
         chk("stall_valid", 64'(bus.o_data_valid), 64'(1));
         chk("stall_data", 64'(bus.o_data), 64'(held));
         chk("stall_index", 64'(bus.o_index), 64'(hidx));
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.i_data_ready = 1'b1;
      @(negedge clk);
      for (int i = 4; i < N; i++) send(rnd16(), rnd16(), 1'b0);
      idle(1);

      // sync arrives with the 4th sample
      for (int i = 0; i < 11; i++) send(rnd16(), rnd16(), i == 3);
      idle(6);

      // reset after 5 bins
      for (int i = 0; i < 5; i++) send(rnd16(), rnd16(), 1'b0);
      @(posedge clk);
      #3;
      rst_n            = 1'b0;
      bus.i_data_valid = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.o_data_valid), 64'(0));
      chk("arst_data", 64'(bus.o_data), 64'(0));
      chk("arst_index", 64'(bus.o_index), 64'(0));
      chk("arst_last", 64'(bus.o_last), 64'(0));
      chk("arst_pv", 64'(pv), 64'(0));
      chk("arst_pidx", 64'(pidx), 64'(0));
      chk("arst_ppow", 64'(ppow), 64'(0));
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) send(rnd16(), rnd16(), 1'b0);
      idle(8);
      chk("drained", 64'(q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_power_stage.md
FFT_POWER_STAGE -- requirements
Module: fft_power_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed width of each real/imag component.
REQ-002 SHALL have parameter FFT_LEN_LOG2, default 10, log2 of bins per frame; legal range 1..16.
REQ-003 SHALL have parameter PIPE_STAGES, default 2, multiply/add latency in cycles; legal values 2 or 3.
REQ-004 SHALL have i_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have i_data  input  2*DATA_W  complex bin: [DATA_W-1:0] real, [2*DATA_W-1:DATA_W] imag, both two's complement.
REQ-007 SHALL have i_data_valid  input  1  upstream sample valid.
REQ-008 SHALL have o_data_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have i_sync  input  1  synchronous frame restart; bin counter returns to 0.
REQ-010 SHALL have o_data  output  2*DATA_W  unsigned power re*re+im*im.
REQ-011 SHALL have o_index  output  FFT_LEN_LOG2  bin index of o_data.
REQ-012 SHALL have o_last  output  1  o_data is bin 2^FFT_LEN_LOG2-1.
REQ-013 SHALL have o_data_valid  output  1  downstream data valid.
REQ-014 SHALL have i_data_ready  input  1  downstream ready.
REQ-015 SHALL have o_peak_valid  output  1  one-cycle pulse: frame peak report valid.
REQ-016 SHALL have o_peak_index  output  FFT_LEN_LOG2  bin of largest power in completed frame.
REQ-017 SHALL have o_peak_power  output  2*DATA_W  power of that bin.

Function
REQ-018 SHALL transfer input when i_data_valid and o_data_ready are both high; output when o_data_valid and i_data_ready are both high.
REQ-019 SHALL advance the pipeline only on enable = !o_data_valid | i_data_ready; o_data_ready SHALL equal enable (combinational, no dependence on i_data_valid).
REQ-020 SHALL present a transferred sample on o_data exactly PIPE_STAGES enabled cycles after acceptance; zero bubbles at full throughput.
REQ-021 SHALL compute power exactly, without saturation or rounding; (-2^(DATA_W-1))^2 * 2 = 2^(2*DATA_W-1) SHALL fit.
REQ-022 SHALL tag each accepted sample with a bin counter value, increment on acceptance, wrap from 2^FFT_LEN_LOG2-1 to 0; o_last = (o_index == max).
REQ-023 SHALL, when i_sync is high, reset the bin counter so that a sample accepted in the same cycle gets index 0; samples already in the pipeline keep their tags.
REQ-024 SHALL track the peak on output transfers: index 0 loads the tracker unconditionally; later bins replace it only if strictly greater (ties keep lower index).
REQ-025 SHALL pulse o_peak_valid for one cycle, the cycle after the o_last transfer, with o_peak_index/o_peak_power stable until the next pulse; not back-pressured.
REQ-026 SHALL hold o_data/o_index/o_last stable while o_data_valid is high and i_data_ready is low.
REQ-027 SHALL ignore i_data when i_data_valid is low; no counter or tracker change.

Reset
REQ-028 SHALL, on i_rst_n low, asynchronously clear o_data_valid, o_peak_valid, bin counter, pipeline valid bits, o_data, o_index, o_last, o_peak_index, o_peak_power to 0.
REQ-029 SHALL discard in-flight samples on reset mid-frame; the first sample after release is bin 0 and no peak pulse is issued for the aborted frame.
REQ-030 SHALL drive o_data_ready high in the first cycle after reset release.

Structure
REQ-031 SHALL take POW_W = 2*DATA_W and the component-packing offsets from the shared package fft_pkg, used also by the FFT wrapper and output controller.
REQ-032 SHALL place squared magnitude in one sub-module, cmplx_mag_sq (enable-gated pipeline, PIPE_STAGES deep); counter, tagging and peak tracker stay in the top.

Verification (DATA_W=16, FFT_LEN_LOG2=3, PIPE_STAGES=2)
REQ-033 SHALL check: re=3, im=-4, ready held high -> o_data=25 two cycles after acceptance, o_index=0.
REQ-034 SHALL check: re=im=-32768 -> o_data=0x80000000 (no overflow).
REQ-035 SHALL check: 8 bins, powers 1,9,4,9,0,2,9,1 -> o_last on 8th output; o_peak_valid one cycle later; peak_index=1, peak_power=9.
REQ-036 SHALL check: i_data_ready low for 5 cycles mid-frame with valid input -> o_data held constant, o_data_ready low, no sample lost or duplicated, indices contiguous.
REQ-037 SHALL check: i_sync with 4th sample -> that sample tagged 0, earlier three emitted with indices 0,1,2, no o_last for them.
REQ-038 SHALL check: i_rst_n low after 5 bins -> all outputs 0 immediately; next frame starts at index 0 and no peak pulse for the aborted frame.
